// File: rtl/bf_pkg.sv
// Shared types and helpers for the serial Brainfuck program loader.
//   bf_op_t    : 3-bit opcode as fetched by the core
//   bf_dec_t   : {valid, op} result of decoding one received ASCII byte
//   rx_state_t : UART receiver states
//   l_state_t  : loader states
package bf_pkg;

   typedef enum logic [2:0] {
      OP_INC_PTR = 3'd0,
      OP_DEC_PTR = 3'd1,
      OP_INC     = 3'd2,
      OP_DEC     = 3'd3,
      OP_OUT     = 3'd4,
      OP_IN      = 3'd5,
      OP_LOOP    = 3'd6,
      OP_END     = 3'd7
   } bf_op_t;

   typedef struct packed {
      logic   valid;
      bf_op_t op;
   } bf_dec_t;

   typedef enum logic [2:0] {
      RX_IDLE    = 3'd0,
      RX_START   = 3'd1,
      RX_DATA    = 3'd2,
      RX_STOP    = 3'd3,
      RX_WAIT_HI = 3'd4
   } rx_state_t;

   typedef enum logic {
      L_LOAD = 1'b0,
      L_DONE = 1'b1
   } l_state_t;

   localparam logic [7:0] ASCII_TERM = 8'h21;
   localparam logic [7:0] ASCII_ESC  = 8'h1B;

   function automatic bf_dec_t bf_decode(input logic [7:0] b);
      bf_dec_t d;
      d.valid = 1'b1;
      d.op    = OP_INC_PTR;
      case (b)
         8'h3E:   d.op = OP_INC_PTR;   // '>'
         8'h3C:   d.op = OP_DEC_PTR;   // '<'
         8'h2B:   d.op = OP_INC;       // '+'
         8'h2D:   d.op = OP_DEC;       // '-'
         8'h2E:   d.op = OP_OUT;       // '.'
         8'h2C:   d.op = OP_IN;        // ','
         8'h5B:   d.op = OP_LOOP;      // '['
         8'h5D:   d.op = OP_END;       // ']'
         default: d.valid = 1'b0;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver with 2-flop input synchronizer.
//   clk, rst   : clock, synchronous active-high reset
//   uart_rx    : asynchronous serial input, idles high
//   byte_data  : last received byte, valid while byte_valid is high
//   byte_valid : 1-cycle pulse, cycle after a good stop-bit sample
//   frame_err  : 1-cycle pulse, cycle after a low stop-bit sample
//
// state      | meaning
// RX_IDLE    | line idle, waiting for a low level
// RX_START   | timing to mid start bit to confirm it
// RX_DATA    | sampling 8 data bits, LSB first
// RX_STOP    | sampling the stop bit
// RX_WAIT_HI | framing error seen, waiting for line to return high
module uart_rx_byte
   import bf_pkg::*;
#(
   parameter int unsigned BIT_CYCLES = 434
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       uart_rx,
   output logic [7:0] byte_data,
   output logic       byte_valid,
   output logic       frame_err
);

   localparam int unsigned CW = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;
   localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYCLES - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(BIT_CYCLES / 2 - 1);

   rx_state_t     state_q, state_d;
   logic          rx_meta_q, rx_sync_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_idx_q, bit_idx_d;
   logic [7:0]    shift_q, shift_d;
   logic          byte_valid_q, byte_valid_d;
   logic          frame_err_q, frame_err_d;
   logic          tick;

   assign tick = (cnt_q == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= RX_IDLE;
         rx_meta_q    <= 1'b1;
         rx_sync_q    <= 1'b1;
         cnt_q        <= '0;
         bit_idx_q    <= '0;
         shift_q      <= '0;
         byte_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         rx_meta_q    <= uart_rx;
         rx_sync_q    <= rx_meta_q;
         cnt_q        <= cnt_d;
         bit_idx_q    <= bit_idx_d;
         shift_q      <= shift_d;
         byte_valid_q <= byte_valid_d;
         frame_err_q  <= frame_err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         RX_IDLE:    if (!rx_sync_q) state_d = RX_START;
         RX_START:   if (tick) state_d = rx_sync_q ? RX_IDLE : RX_DATA;
         RX_DATA:    if (tick && bit_idx_q == 3'd7) state_d = RX_STOP;
         RX_STOP:    if (tick) state_d = rx_sync_q ? RX_IDLE : RX_WAIT_HI;
         RX_WAIT_HI: if (rx_sync_q) state_d = RX_IDLE;
         default:    state_d = RX_IDLE;
      endcase
   end

   // Bit timer is a down-counter; every sample point is its terminal count.
   always_comb begin
      cnt_d        = cnt_q;
      bit_idx_d    = bit_idx_q;
      shift_d      = shift_q;
      byte_valid_d = 1'b0;
      frame_err_d  = 1'b0;
      case (state_q)
         RX_IDLE: begin
            cnt_d     = HALF_LAST;
            bit_idx_d = '0;
         end
         RX_START: cnt_d = tick ? BIT_LAST : cnt_q - 1'b1;
         RX_DATA: begin
            if (tick) begin
               shift_d   = {rx_sync_q, shift_q[7:1]};
               bit_idx_d = bit_idx_q + 3'd1;
               cnt_d     = BIT_LAST;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         RX_STOP: begin
            if (tick) begin
               byte_valid_d = rx_sync_q;
               frame_err_d  = !rx_sync_q;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign byte_data  = shift_q;
   assign byte_valid = byte_valid_q;
   assign frame_err  = frame_err_q;

endmodule

// File: rtl/bf_prog_loader.sv
// Serial program loader: receives ASCII Brainfuck over UART, filters to
// opcodes, writes them to program memory and holds the core until '!'.
//   clk, rst      : clock, synchronous active-high reset
//   uart_rx       : serial input
//   wr_en/wr_addr/wr_code : 1-cycle program-memory write
//   prog_len      : number of opcodes stored (saturates at DEPTH)
//   core_hold     : high while loading
//   load_done     : high once the program is terminated
//   err_frame/err_overflow/err_bracket : sticky errors, cleared by ESC
//
// state  | meaning
// L_LOAD | accepting opcodes, core held
// L_DONE | program terminated, only ESC is acted on
module bf_prog_loader
   import bf_pkg::*;
#(
   parameter  int unsigned CLK_HZ     = 50_000_000,
   parameter  int unsigned BAUD       = 115200,
   parameter  int unsigned DEPTH      = 256,
   localparam int unsigned AW         = $clog2(DEPTH),
   localparam int unsigned BIT_CYCLES = CLK_HZ / BAUD
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          uart_rx,
   output logic          wr_en,
   output logic [AW-1:0] wr_addr,
   output logic [2:0]    wr_code,
   output logic [AW:0]   prog_len,
   output logic          core_hold,
   output logic          load_done,
   output logic          err_frame,
   output logic          err_overflow,
   output logic          err_bracket
);

   localparam logic [AW:0] LEN_FULL = (AW + 1)'(DEPTH);

   logic       [7:0] byte_data;
   logic             byte_valid;
   logic             frame_err;
   bf_dec_t          dec;

   l_state_t         load_q, load_d;
   logic    [AW:0]   prog_len_q, prog_len_d;
   logic    [AW:0]   depth_q, depth_d;
   logic             wr_en_q, wr_en_d;
   logic    [AW-1:0] wr_addr_q, wr_addr_d;
   logic    [2:0]    wr_code_q, wr_code_d;
   logic             err_frame_q, err_frame_d;
   logic             err_overflow_q, err_overflow_d;
   logic             err_bracket_q, err_bracket_d;

   uart_rx_byte #(.BIT_CYCLES(BIT_CYCLES)) u_rx (
      .clk        (clk),
      .rst        (rst),
      .uart_rx    (uart_rx),
      .byte_data  (byte_data),
      .byte_valid (byte_valid),
      .frame_err  (frame_err)
   );

   assign dec = bf_decode(byte_data);

   always_ff @(posedge clk) begin
      if (rst) begin
         load_q         <= L_LOAD;
         prog_len_q     <= '0;
         depth_q        <= '0;
         wr_en_q        <= 1'b0;
         wr_addr_q      <= '0;
         wr_code_q      <= '0;
         err_frame_q    <= 1'b0;
         err_overflow_q <= 1'b0;
         err_bracket_q  <= 1'b0;
      end else begin
         load_q         <= load_d;
         prog_len_q     <= prog_len_d;
         depth_q        <= depth_d;
         wr_en_q        <= wr_en_d;
         wr_addr_q      <= wr_addr_d;
         wr_code_q      <= wr_code_d;
         err_frame_q    <= err_frame_d;
         err_overflow_q <= err_overflow_d;
         err_bracket_q  <= err_bracket_d;
      end
   end

   always_comb begin
      load_d = load_q;
      if (byte_valid) begin
         if (load_q == L_LOAD && byte_data == ASCII_TERM) load_d = L_DONE;
         if (load_q == L_DONE && byte_data == ASCII_ESC)  load_d = L_LOAD;
      end
   end

   always_comb begin
      core_hold = (load_q == L_LOAD);
      load_done = (load_q == L_DONE);
   end

   always_comb begin
      prog_len_d     = prog_len_q;
      depth_d        = depth_q;
      wr_en_d        = 1'b0;
      wr_addr_d      = wr_addr_q;
      wr_code_d      = wr_code_q;
      err_frame_d    = err_frame_q | frame_err;
      err_overflow_d = err_overflow_q;
      err_bracket_d  = err_bracket_q;
      if (byte_valid) begin
         if (load_q == L_LOAD) begin
            if (byte_data == ASCII_TERM) begin
               if (depth_q != '0) err_bracket_d = 1'b1;
            end else if (dec.valid) begin
               if (prog_len_q == LEN_FULL) begin
                  err_overflow_d = 1'b1;
               end else begin
                  wr_en_d    = 1'b1;
                  wr_addr_d  = prog_len_q[AW-1:0];
                  wr_code_d  = dec.op;
                  prog_len_d = prog_len_q + 1'b1;
                  // An unmatched ']' is still stored; depth stays at 0.
                  if (dec.op == OP_LOOP) begin
                     depth_d = depth_q + 1'b1;
                  end else if (dec.op == OP_END) begin
                     if (depth_q == '0) err_bracket_d = 1'b1;
                     else               depth_d = depth_q - 1'b1;
                  end
               end
            end
         end else if (byte_data == ASCII_ESC) begin
            prog_len_d     = '0;
            depth_d        = '0;
            err_frame_d    = 1'b0;
            err_overflow_d = 1'b0;
            err_bracket_d  = 1'b0;
         end
      end
   end

   assign wr_en        = wr_en_q;
   assign wr_addr      = wr_addr_q;
   assign wr_code      = wr_code_q;
   assign prog_len     = prog_len_q;
   // The receiver's error pulse is already one cycle after the stop sample.
   assign err_frame    = err_frame_q | frame_err;
   assign err_overflow = err_overflow_q;
   assign err_bracket  = err_bracket_q;

endmodule

// File: doc/bf_prog_loader.md
# bf_prog_loader

Receives a Brainfuck program as ASCII over an 8N1 UART line and writes it into the program memory that drives the core's 3-bit opcode fetch. Filters non-command bytes and checks bracket balance. Holds the core stalled until a terminator byte arrives. Sits directly upstream of the program ROM/RAM and the core, replacing the fixed compiled-in program with a serially loaded one.

## Interface
- `CLK_HZ`, default 50_000_000: `clk` frequency.
- `BAUD`, default 115200: line rate. `BIT_CYCLES = CLK_HZ/BAUD` (integer division; 434 at defaults).
- `DEPTH`, default 256: program memory depth in opcodes. `AW = $clog2(DEPTH)`.
- `clk`, in, 1: the single clock.
- `rst`, in, 1: synchronous, active-high reset.
- `uart_rx`, in, 1: asynchronous serial input; idles high.
- `wr_en`, out, 1: one-cycle program-memory write strobe.
- `wr_addr`, out, AW: write address.
- `wr_code`, out, 3: opcode to write.
- `prog_len`, out, AW+1: number of opcodes stored. The core treats `addr >= prog_len` as finished.
- `core_hold`, out, 1: high while loading; stalls the core and holds it at PC 0.
- `load_done`, out, 1: high once a program has been terminated.
- `err_frame`, out, 1: sticky; a stop bit was sampled low.
- `err_overflow`, out, 1: sticky; more than DEPTH opcodes were received.
- `err_bracket`, out, 1: sticky; a `]` arrived with depth 0, or depth was non-zero at the terminator.

## Operation
- RX path: a 2-flop synchronizer feeds the RX FSM, which has states RX_IDLE, RX_START, RX_DATA, RX_STOP and RX_WAIT_HI.
  - RX_IDLE: a low level on the synchronized line moves to RX_START.
  - RX_START: at `BIT_CYCLES/2` the line is re-sampled. Low goes to RX_DATA. High is a false start and returns to RX_IDLE.
  - RX_DATA: 8 samples, one every `BIT_CYCLES`, LSB first.
  - RX_STOP: one sample after a further `BIT_CYCLES`. High delivers the byte. Low sets `err_frame`, discards the byte, and goes to RX_WAIT_HI.
  - RX_WAIT_HI: waits for the line to go high, then returns to RX_IDLE.
- Loader FSM has two states, L_LOAD and L_DONE. Reset enters L_LOAD.
- Byte mapping in L_LOAD: `>`=0, `<`=1, `+`=2, `-`=3, `.`=4, `,`=5, `[`=6, `]`=7.
  - A mapped byte writes `wr_code` at `wr_addr = prog_len`, then increments `prog_len`.
  - All other bytes are ignored.
- Bracket depth counter (AW+1 bits):
  - `[` increments it.
  - `]` at depth 0 sets `err_bracket`; the opcode is still written.
- `!` (0x21) in L_LOAD moves to L_DONE. It sets `err_bracket` if depth is not 0, drops `core_hold` and raises `load_done`.
- Overflow: a mapped byte when `prog_len == DEPTH` sets `err_overflow`. No write occurs and `prog_len` saturates at DEPTH.
- In L_DONE every byte is ignored except ESC (0x1B). ESC returns to L_LOAD and, in the same cycle, clears `prog_len`, depth, `load_done` and all three error flags, and raises `core_hold`.
- `!` received in L_DONE is ignored.

## Timing
- Reset values:
  - `wr_en`, `wr_addr`, `wr_code`, `prog_len`, `load_done` and the error flags are all 0.
  - `core_hold` is 1.
  - The RX FSM is in RX_IDLE and the loader in L_LOAD.
- The internal `byte_valid` pulses for 1 cycle, on the cycle after the stop-bit sample.
- `wr_en` is registered and high for exactly 1 cycle, on the cycle after `byte_valid`.
- `prog_len` shows the incremented value in that same cycle, so it equals `wr_addr + 1` while `wr_en` is high.
- `core_hold` falls, and `load_done` rises, on the cycle after `byte_valid` for the `!` byte.
- `err_*` flags assert on the cycle after their triggering sample or byte.
- `rst` mid-frame aborts the byte with no write, and all outputs return to their reset values on the next edge.
- Back-to-back frames with one stop bit are received without loss. A minimum of 1 stop bit is required.

## Structure
- Package `bf_pkg` holds:
  - the opcode enum `bf_op_t` (3-bit, values above);
  - constants `ASCII_TERM = 8'h21` and `ASCII_ESC = 8'h1B`;
  - the function `bf_decode(byte) -> {valid, bf_op_t}`.
- Sub-module `uart_rx_byte` contains the synchronizer and RX FSM. It has `BIT_CYCLES` as a parameter and outputs `byte_data[7:0]`, `byte_valid` and `frame_err`.
- `bf_prog_loader` contains the loader FSM, the depth counter and the output registers.

## Test plan
All scenarios run with `CLK_HZ=16`, `BAUD=1` (`BIT_CYCLES=16`).

1. Send `+[-]!`: 4 writes, codes 2,6,3,7 at addresses 0..3; `prog_len=4`; `load_done=1`, `core_hold=0`; no errors.
2. Send `a+ \n>!`: only 2 writes, codes 2,0; `prog_len=2`.
3. Send `]!`: `err_bracket` rises on `]`, code 7 written at address 0. Send `[[]!`: `err_bracket=1` at the terminator.
4. Frame with the stop bit held low, then `+`: `err_frame=1`, no write for the bad frame, `+` written at address 0. A 4-cycle low glitch produces no byte.
5. With `DEPTH=4`, send `+++++!`: 4 writes; `prog_len=4`; `err_overflow=1`; `load_done=1`.
6. After scenario 1, send ESC then `>!`: on ESC `core_hold=1`, `prog_len=0`, `load_done=0`; then 1 write of code 0 at address 0. Assert `rst` mid-frame: no write, and all outputs return to their reset values.
